// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer family.
package mux_pkg;

   localparam int unsigned WIDTH_DEF  = 32;
   localparam int unsigned NUM_IN_DEF = 2;

   // Ceiling log2, usable in parameter expressions; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed lowest-index-wins.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int unsigned NUM_IN = NUM_IN_DEF,
   localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              fixed,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  idx,
   output logic              any
);

   logic [NUM_IN-1:0] upper_mask;
   logic [NUM_IN-1:0] upper_req;
   logic [NUM_IN-1:0] pick;

   // Prefer requesters at or above the start point; otherwise wrap to the lowest one.
   always_comb begin
      int unsigned start;
      logic        found;
      start = fixed ? 32'd0 : 32'(ptr);
      if (start >= NUM_IN) start = 0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         upper_mask[i] = (i >= start);
      end
      upper_req = req & upper_mask;
      pick      = (|upper_req) ? upper_req : req;
      grant     = '0;
      idx       = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (!found && pick[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            idx      = SEL_W'(i);
         end
      end
      any = found;
   end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrated multiplexer with a one-entry registered output stage.
module mux_arb_nto1
   import mux_pkg::*;
#(
   parameter  int unsigned WIDTH  = WIDTH_DEF,
   parameter  int unsigned NUM_IN = NUM_IN_DEF,
   localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    prio_fixed,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [SEL_W-1:0]  ptr;
   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  gidx;
   logic              gany;
   logic              load_en;
   logic              take;
   logic [WIDTH-1:0]  next_word;
   logic [SEL_W-1:0]  next_ptr;

   rr_arbiter #(
      .NUM_IN (NUM_IN)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .fixed (prio_fixed),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // Register can accept when empty or being drained this cycle; nothing is taken in reset.
   assign load_en  = ~out_valid | out_ready;
   assign take     = gany & load_en & ~Rst;
   assign in_ready = (Rst || !load_en) ? '0 : grant;
   assign next_ptr = (gidx == SEL_W'(NUM_IN - 1)) ? '0 : gidx + SEL_W'(1);

   // Select the granted channel's word (grant is one-hot).
   always_comb begin
      next_word = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (grant[i]) next_word = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else begin
         if (take) begin
            out_valid <= 1'b1;
            out_data  <= next_word;
            out_sel   <= gidx;
            ptr       <= next_ptr;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Scoreboard bench for mux_arb_nto1: a 4-input and a 3-input instance.
module tb_mux_arb_nto1;

   logic        Clk = 1'b0;
   logic        Rst;

   logic [127:0] a_in_data;
   logic [3:0]   a_in_valid, a_in_ready;
   logic         a_prio, a_out_valid, a_out_ready;
   logic [31:0]  a_out_data;
   logic [1:0]   a_out_sel;

   logic [95:0]  b_in_data;
   logic [2:0]   b_in_valid, b_in_ready;
   logic         b_prio, b_out_valid, b_out_ready;
   logic [31:0]  b_out_data;
   logic [1:0]   b_out_sel;

   int errors = 0;
   int checks = 0;

   logic [33:0] qa[$];
   logic [33:0] qb[$];
   logic [33:0] ea, eb;

   always #5 Clk = ~Clk;

   mux_arb_nto1 #(.WIDTH(32), .NUM_IN(4)) u_a (
      .Clk(Clk), .Rst(Rst), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .prio_fixed(a_prio), .out_data(a_out_data),
      .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready));

   mux_arb_nto1 #(.WIDTH(32), .NUM_IN(3)) u_b (
      .Clk(Clk), .Rst(Rst), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .prio_fixed(b_prio), .out_data(b_out_data),
      .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge Clk);
      #1;
   endtask

   // Monitor for the 4-input instance: every delivered word must match the queue head.
   always @(negedge Clk) begin
      if (!Rst && a_out_valid && a_out_ready) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_deliver: got sel=%0d data=%h expected no word", a_out_sel, a_out_data);
         end else begin
            ea = qa.pop_front();
            if ({a_out_sel, a_out_data} !== ea) begin
               errors++;
               $display("FAIL a_deliver: got sel=%0d data=%h expected sel=%0d data=%h",
                        a_out_sel, a_out_data, ea[33:32], ea[31:0]);
            end
         end
      end
   end

   // Monitor for the 3-input instance.
   always @(negedge Clk) begin
      if (!Rst && b_out_valid && b_out_ready) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_deliver: got sel=%0d data=%h expected no word", b_out_sel, b_out_data);
         end else begin
            eb = qb.pop_front();
            if ({b_out_sel, b_out_data} !== eb) begin
               errors++;
               $display("FAIL b_deliver: got sel=%0d data=%h expected sel=%0d data=%h",
                        b_out_sel, b_out_data, eb[33:32], eb[31:0]);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rr_sel[8];
      logic [2:0] b_vec[5];
      int b_sel[5];
      rr_sel = '{0, 1, 2, 3, 0, 1, 2, 3};
      b_vec  = '{3'b100, 3'b011, 3'b010, 3'b111, 3'b111};
      b_sel  = '{2, 0, 1, 2, 0};

      // Reset for two cycles with every channel offering a word.
      Rst         = 1'b1;
      a_in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      a_in_valid  = 4'hF;
      a_prio      = 1'b0;
      a_out_ready = 1'b1;
      b_in_data   = {32'hB2, 32'hB1, 32'hB0};
      b_in_valid  = 3'b111;
      b_prio      = 1'b0;
      b_out_ready = 1'b1;
      @(negedge Clk);
      check("rst_a_in_ready", 64'(a_in_ready), 64'h0);
      check("rst_b_in_ready", 64'(b_in_ready), 64'h0);
      next_cycle();
      @(negedge Clk);
      check("rst_a_in_ready2", 64'(a_in_ready), 64'h0);
      check("rst_a_out_valid", 64'(a_out_valid), 64'h0);
      check("rst_a_out_data", 64'(a_out_data), 64'h0);
      check("rst_a_out_sel", 64'(a_out_sel), 64'h0);
      check("rst_b_out_valid", 64'(b_out_valid), 64'h0);
      next_cycle();
      Rst        = 1'b0;
      b_in_valid = 3'b000;

      // Round-robin, all channels valid, consumer always ready.
      for (int k = 0; k < 8; k++) begin
         qa.push_back({2'(rr_sel[k]), 32'hA0 + 32'(rr_sel[k])});
         @(negedge Clk);
         check("rr_in_ready", 64'(a_in_ready), 64'(4'b0001 << rr_sel[k]));
         next_cycle();
      end

      // Fixed priority: channels 1 and 3 valid, channel 1 always wins.
      a_prio     = 1'b1;
      a_in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         qa.push_back({2'd1, 32'hA1});
         @(negedge Clk);
         check("fixed_in_ready", 64'(a_in_ready), 64'h2);
         next_cycle();
      end
      a_in_valid = 4'b1000;
      qa.push_back({2'd3, 32'hA3});
      @(negedge Clk);
      check("fixed_ch3_ready", 64'(a_in_ready), 64'h8);
      next_cycle();
      a_in_valid = 4'b0000;
      @(negedge Clk);
      check("idle_in_ready", 64'(a_in_ready), 64'h0);
      next_cycle();
      @(negedge Clk);
      check("drained_out_valid", 64'(a_out_valid), 64'h0);
      next_cycle();

      // Back-pressure: hold the word from channel 2 for five cycles.
      a_prio            = 1'b0;
      a_in_data[95:64]  = 32'h12345678;
      a_in_valid        = 4'b0100;
      qa.push_back({2'd2, 32'h12345678});
      @(negedge Clk);
      check("bp_load_ready", 64'(a_in_ready), 64'h4);
      next_cycle();
      a_out_ready      = 1'b0;
      a_in_valid       = 4'b0001;
      a_in_data[31:0]  = 32'hC0;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         check("bp_out_valid", 64'(a_out_valid), 64'h1);
         check("bp_out_data", 64'(a_out_data), 64'h12345678);
         check("bp_out_sel", 64'(a_out_sel), 64'h2);
         check("bp_in_ready", 64'(a_in_ready), 64'h0);
         next_cycle();
      end
      a_out_ready = 1'b1;
      qa.push_back({2'd0, 32'hC0});
      @(negedge Clk);
      check("bp_release_ready", 64'(a_in_ready), 64'h1);
      next_cycle();
      a_in_valid = 4'b0000;
      @(negedge Clk);
      next_cycle();

      // Mid-operation reset discards a held word.
      a_in_data[31:0] = 32'hDEADBEEF;
      a_in_valid      = 4'b0001;
      a_out_ready     = 1'b0;
      @(negedge Clk);
      check("mr_load_ready", 64'(a_in_ready), 64'h1);
      next_cycle();
      a_in_valid = 4'b0000;
      @(negedge Clk);
      check("mr_held_valid", 64'(a_out_valid), 64'h1);
      check("mr_held_data", 64'(a_out_data), 64'hDEADBEEF);
      next_cycle();
      Rst         = 1'b1;
      a_out_ready = 1'b1;
      a_in_valid  = 4'hF;
      a_in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      @(negedge Clk);
      check("mr_rst_in_ready", 64'(a_in_ready), 64'h0);
      next_cycle();
      Rst = 1'b0;
      qa.push_back({2'd0, 32'hA0});
      @(negedge Clk);
      check("mr_out_valid", 64'(a_out_valid), 64'h0);
      check("mr_out_data", 64'(a_out_data), 64'h0);
      check("mr_out_sel", 64'(a_out_sel), 64'h0);
      check("mr_first_grant", 64'(a_in_ready), 64'h1);
      next_cycle();
      a_in_valid = 4'b0000;
      @(negedge Clk);
      next_cycle();

      // Three-input instance: pointer wrap from channel 2 back to 0.
      for (int k = 0; k < 5; k++) begin
         b_in_valid = b_vec[k];
         qb.push_back({2'(b_sel[k]), 32'hB0 + 32'(b_sel[k])});
         @(negedge Clk);
         check("wrap_in_ready", 64'(b_in_ready), 64'(3'b001 << b_sel[k]));
         next_cycle();
      end
      b_in_valid = 3'b000;
      repeat (2) begin
         @(negedge Clk);
         next_cycle();
      end

      check("a_queue_empty", 64'(qa.size()), 64'h0);
      check("b_queue_empty", 64'(qb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
